gn_collector: RTL
=================

Name: gn_collector

Overview:
- Golden-nonce collection stage between the two pbkdfengine/salsaengine cores and the host output shift buffer.
- Captures every golden_nonce_match pulse from both cores into a FIFO, including two matches in the same cycle. The current single-select mux drops one nonce in that case.
- Also keeps the newest-two register pair (latest_a/latest_b) that the host outbuf frame expects.
- Flushed on the new-work strobe (loadnonce_d), because hashes produced during a work load are invalid.

Parameters:
DEPTHBITS, 3, log2 of FIFO depth (depth = 8 entries).
NONCEW, 32, nonce width in bits.

Ports:
hash_clk  in  1  core clock; all state changes on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
flush  in  1  single-cycle clear strobe, driven from loadnonce_d.
match_1  in  1  golden_nonce_match from core 1.
nonce_1  in  NONCEW  golden_nonce_out from core 1; valid when match_1=1.
match_2  in  1  golden_nonce_match from core 2.
nonce_2  in  NONCEW  golden_nonce_out from core 2; valid when match_2=1.
pop  in  1  host read strobe; removes the head entry.
dout  out  NONCEW  head entry (first-word-fall-through); 0 when empty.
empty  out  1  1 when count=0.
count  out  DEPTHBITS+1  number of stored entries, 0..2^DEPTHBITS.
overflow  out  1  sticky; set when any match could not be stored.
latest_a  out  NONCEW  most recently accepted nonce.
latest_b  out  NONCEW  nonce accepted before latest_a.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - count=0, empty=1, dout=0, overflow=0, latest_a=0, latest_b=0.
  - Read/write pointers = 0.
  - Storage RAM contents are don't-care.
- Priority each cycle: flush > pop > push.
- flush=1:
  - Next cycle: count=0, pointers=0, overflow=0, latest_a=latest_b=0.
  - match_1/match_2/pop in the same cycle are discarded.
- Pop:
  - pop=1 with count>0: read pointer advances by 1 and count decrements.
  - pop=1 with count=0: ignored; no underflow and no flag change.
- Free slots for this cycle: free = 2^DEPTHBITS - count + (pop && count>0). A pop therefore frees its slot for a same-cycle push.
- Push order:
  - Core 1 is always written before core 2.
  - Both matches: nonce_1 at wptr, nonce_2 at wptr+1; wptr += 2; count += 2 - popped.
  - free=1 with both matches: store nonce_1 only, drop nonce_2, set overflow.
  - free=0 with any match: drop all, set overflow.
- Pointers are DEPTHBITS wide and wrap modulo 2^DEPTHBITS. count is the authoritative full/empty indicator.
- latest pair: updated only by accepted nonces.
  - Single accept of x: latest_b <= latest_a, latest_a <= x.
  - Double accept: latest_b <= nonce_1, latest_a <= nonce_2.
  - Dropped nonces never update latest_a/latest_b.
- A nonce value of 0 is stored like any other; there is no sentinel filtering.
- Latency:
  - A match at cycle N is visible on dout, count and latest_a at cycle N+1, if the FIFO was empty.
  - pop at cycle N presents the next entry on dout at N+1.
- dout is registered or a read-before-write LUTRAM view. It must equal the head entry whenever empty=0, and 0 when empty=1.
- overflow is cleared only by reset_n or flush.
- Synthesis: storage maps to distributed RAM. No combinational path from match_* to dout.

Test Plan:
1. Reset, then match_1 with nonce_1=32'h0000_1234 for one cycle:
   - Next cycle: dout=32'h0000_1234, count=1, empty=0.
   - latest_a=32'h0000_1234, latest_b=0.
2. Same-cycle match_1 (32'hAAAA_0001) and match_2 (32'hBBBB_0002), then pop twice:
   - dout reads 32'hAAAA_0001, then 32'hBBBB_0002, then empty=1.
   - latest_a=32'hBBBB_0002, latest_b=32'hAAAA_0001.
3. Fill to 7 entries, then a double match:
   - count=8, core 1 nonce stored, core 2 dropped, overflow=1.
   - A further single match: count stays 8, latest_a unchanged.
4. FIFO full (8 entries), pop and match_1 (32'h0000_00FF) in the same cycle:
   - count stays 8, overflow stays 0.
   - 32'h0000_00FF is read out after the 7 older entries.
5. Push/pop 20 entries, values 1..20, with random gaps and depth ≤ 8:
   - Output order is exactly 1..20, across pointer wrap.
6. Flush asserted with count=5, overflow=1 and a simultaneous match_2:
   - Next cycle: count=0, overflow=0, latest_a=latest_b=0.
   - The match_2 nonce is not stored.
   - Also assert reset_n low mid-sequence: outputs clear immediately, without a clock edge.

Source files
------------

// File: rtl/gn_collector.sv
// gn_collector: golden-nonce collection FIFO between the two hashing cores and
// the host output shift buffer. Every accepted golden_nonce_match is queued,
// including two matches in the same cycle (core 1 is written first). A flush
// from the new-work strobe discards queued nonces, since hashes produced while
// new work is loading are invalid. The newest two accepted nonces are also kept
// in latest_a/latest_b for the host frame.
//
// Ports:
//   hash_clk            core clock, rising edge
//   reset_n             asynchronous active-low reset
//   flush               single-cycle clear (loadnonce_d)
//   match_1 / nonce_1   golden nonce from core 1
//   match_2 / nonce_2   golden nonce from core 2
//   pop                 host read strobe, removes the head entry
//   dout                head entry (first-word-fall-through), 0 when empty
//   empty, count        occupancy
//   overflow            sticky drop indicator, cleared by reset or flush
//   latest_a/latest_b   newest and second-newest accepted nonce
module gn_collector #(
    parameter int DEPTHBITS = 3,
    parameter int NONCEW    = 32
) (
    input  logic                 hash_clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 match_1,
    input  logic [NONCEW-1:0]    nonce_1,
    input  logic                 match_2,
    input  logic [NONCEW-1:0]    nonce_2,
    input  logic                 pop,
    output logic [NONCEW-1:0]    dout,
    output logic                 empty,
    output logic [DEPTHBITS:0]   count,
    output logic                 overflow,
    output logic [NONCEW-1:0]    latest_a,
    output logic [NONCEW-1:0]    latest_b
);

    localparam int DEPTH = 1 << DEPTHBITS;

    logic [NONCEW-1:0]    mem [DEPTH];
    logic [DEPTHBITS-1:0] wptr;
    logic [DEPTHBITS-1:0] rptr;
    logic [DEPTHBITS-1:0] wptr_2;
    logic [DEPTHBITS+1:0] free;
    logic                 do_pop;
    logic                 acc_1;
    logic                 acc_2;
    logic                 drop;

    // A pop frees its slot for a push in the same cycle. Core 1 takes the
    // first free slot, so with one slot left only core 2 is dropped.
    always_comb begin
        do_pop = pop && (count != '0) && !flush;
        free   = (DEPTHBITS+2)'(DEPTH) - {1'b0, count} + (DEPTHBITS+2)'(do_pop);
        acc_1  = !flush && match_1 && (free != '0);
        acc_2  = !flush && match_2 &&
                 (acc_1 ? (free >= (DEPTHBITS+2)'(2)) : (free != '0));
        drop   = !flush && ((match_1 && !acc_1) || (match_2 && !acc_2));
        wptr_2 = acc_1 ? wptr + DEPTHBITS'(1) : wptr;
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge hash_clk) begin
        if (acc_1) mem[wptr]   <= nonce_1;
        if (acc_2) mem[wptr_2] <= nonce_2;
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            latest_a <= '0;
            latest_b <= '0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            latest_a <= '0;
            latest_b <= '0;
        end else begin
            rptr  <= rptr + DEPTHBITS'(do_pop);
            wptr  <= wptr + DEPTHBITS'(acc_1) + DEPTHBITS'(acc_2);
            count <= count + (DEPTHBITS+1)'(acc_1) + (DEPTHBITS+1)'(acc_2)
                           - (DEPTHBITS+1)'(do_pop);
            if (drop) overflow <= 1'b1;
            if (acc_1 && acc_2) begin
                latest_b <= nonce_1;
                latest_a <= nonce_2;
            end else if (acc_1) begin
                latest_b <= latest_a;
                latest_a <= nonce_1;
            end else if (acc_2) begin
                latest_b <= latest_a;
                latest_a <= nonce_2;
            end
        end
    end

    // Read path depends only on registered state, never on match_*.
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rptr];

endmodule
